// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - two-requester register-file controller with init sweep and round-robin arbitration
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-low reset
//   a_*/b_* req,wr,adr,  requester A/B operation fields (adr = write or R address,
//   sadr,din             sadr = S read address, din = write data)
//   a_gnt, b_gnt         combinational accept strobes (fields captured while high)
//   W_Adr, Din, we_pulse register-file write port
//   R_Adr, S_Adr         register-file read addresses
//   R_in, S_in           register-file read data (combinational from R_Adr/S_Adr)
//   R_out, S_out         registered read results, valid with rd_valid pulse
//   rd_valid, rd_owner   read-complete pulse and owner (0 = A, 1 = B)
//   busy                 high in every state except IDLE
module regfile_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_wr,
    input  logic        b_wr,
    input  logic [2:0]  a_adr,
    input  logic [2:0]  b_adr,
    input  logic [2:0]  a_sadr,
    input  logic [2:0]  b_sadr,
    input  logic [3:0]  a_din,
    input  logic [3:0]  b_din,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        we_pulse,
    output logic [3:0]  Din,
    input  logic [15:0] R_in,
    input  logic [15:0] S_in,
    output logic [15:0] R_out,
    output logic [15:0] S_out,
    output logic        rd_valid,
    output logic        rd_owner,
    output logic        busy
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR, ST_RD} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       last_b;      // 1 = B was granted most recently
    logic [2:0] l_adr;
    logic [3:0] l_din;
    logic       l_id;
    logic [2:0] w_adr_q;
    logic [3:0] din_q;

    logic       sel_wr;
    logic [2:0] sel_adr;
    logic [2:0] sel_sadr;
    logic [3:0] sel_din;

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        state_nxt = state;
        case (state)
            ST_INIT: if (cnt == 3'd7) state_nxt = ST_IDLE;
            ST_IDLE: begin
                // Gated by reset so nothing is reported as accepted while the
                // state register is about to be forced back to INIT.
                if (reset) begin
                    if (a_req && (!b_req || last_b)) a_gnt = 1'b1;
                    else if (b_req)                  b_gnt = 1'b1;
                end
                if (a_gnt) state_nxt = a_wr ? ST_WR : ST_RD;
                if (b_gnt) state_nxt = b_wr ? ST_WR : ST_RD;
            end
            ST_WR:   state_nxt = ST_IDLE;
            ST_RD:   state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign sel_wr   = b_gnt ? b_wr   : a_wr;
    assign sel_adr  = b_gnt ? b_adr  : a_adr;
    assign sel_sadr = b_gnt ? b_sadr : a_sadr;
    assign sel_din  = b_gnt ? b_din  : a_din;

    assign we_pulse = reset && (state == ST_INIT || state == ST_WR);
    assign busy     = (state != ST_IDLE);

    // The write port shows the live address/data during INIT and WR and
    // otherwise replays whatever it last presented.
    always_comb begin
        W_Adr = w_adr_q;
        Din   = din_q;
        if (state == ST_INIT) begin
            W_Adr = cnt;
            Din   = 4'd0;
        end else if (state == ST_WR) begin
            W_Adr = l_adr;
            Din   = l_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_INIT;
            cnt      <= 3'd0;
            last_b   <= 1'b1;
            l_adr    <= 3'd0;
            l_din    <= 4'd0;
            l_id     <= 1'b0;
            w_adr_q  <= 3'd0;
            din_q    <= 4'd0;
            R_Adr    <= 3'd0;
            S_Adr    <= 3'd0;
            R_out    <= 16'd0;
            S_out    <= 16'd0;
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= (state == ST_RD);
            if (state == ST_INIT) begin
                cnt     <= cnt + 3'd1;
                w_adr_q <= cnt;
                din_q   <= 4'd0;
            end
            if (state == ST_WR) begin
                w_adr_q <= l_adr;
                din_q   <= l_din;
            end
            if (a_gnt || b_gnt) begin
                last_b <= b_gnt;
                l_adr  <= sel_adr;
                l_din  <= sel_din;
                l_id   <= b_gnt;
                // Read addresses move only on a read grant so they stay
                // stable across the following writes.
                if (!sel_wr) begin
                    R_Adr <= sel_adr;
                    S_Adr <= sel_sadr;
                end
            end
            if (state == ST_RD) begin
                R_out    <= R_in;
                S_out    <= S_in;
                rd_owner <= l_id;
            end
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - table-driven bench for regfile_ctrl
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, a_wr, b_wr;
    logic [2:0]  a_adr, b_adr, a_sadr, b_sadr;
    logic [3:0]  a_din, b_din;
    logic        a_gnt, b_gnt;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        we_pulse;
    logic [3:0]  Din;
    logic [15:0] R_in, S_in, R_out, S_out;
    logic        rd_valid, rd_owner, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
        .a_adr(a_adr), .b_adr(b_adr), .a_sadr(a_sadr), .b_sadr(b_sadr),
        .a_din(a_din), .b_din(b_din),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .we_pulse(we_pulse), .Din(Din),
        .R_in(R_in), .S_in(S_in), .R_out(R_out), .S_out(S_out),
        .rd_valid(rd_valid), .rd_owner(rd_owner), .busy(busy)
    );

    // Register-file model: 4-bit cells read back with an 0xFFF upper pad.
    logic [3:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 4'd0;
    always @(posedge clk) if (we_pulse) mem[W_Adr] <= Din;
    assign R_in = {12'hFFF, mem[R_Adr]};
    assign S_in = {12'hFFF, mem[S_Adr]};

    typedef struct {
        logic        rn;
        logic        ar, aw; logic [2:0] aa, as; logic [3:0] ad;
        logic        br, bw; logic [2:0] ba, bs; logic [3:0] bd;
        logic [50:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rn,
                       input logic ar, input logic aw, input logic [2:0] aa, input logic [2:0] as, input logic [3:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [2:0] bs, input logic [3:0] bd,
                       input logic eag, input logic ebg, input logic ewe, input logic [2:0] ewa, input logic [3:0] edi,
                       input logic ebz, input logic erv, input logic [15:0] ero, input logic [15:0] eso,
                       input logic eow, input logic [2:0] era, input logic [2:0] esa);
        vec_t v;
        v.rn = rn;
        v.ar = ar; v.aw = aw; v.aa = aa; v.as = as; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bs = bs; v.bd = bd;
        v.exp = {eag, ebg, ewe, ewa, edi, ebz, erv, ero, eso, eow, era, esa};
        vecs.push_back(v);
    endtask

    function automatic logic [50:0] outs();
        return {a_gnt, b_gnt, we_pulse, W_Adr, Din, busy, rd_valid, R_out, S_out, rd_owner, R_Adr, S_Adr};
    endfunction

    task automatic check(input string name, input logic [50:0] got, input logic [50:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {gnt_a,gnt_b,we,wadr,din,busy,rv,rout,sout,own,radr,sadr}=%h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rn;
        a_req = v.ar; a_wr = v.aw; a_adr = v.aa; a_sadr = v.as; a_din = v.ad;
        b_req = v.br; b_wr = v.bw; b_adr = v.ba; b_sadr = v.bs; b_din = v.bd;
    endtask

    initial begin
        reset = 1'b0;
        a_req = 0; a_wr = 0; a_adr = 0; a_sadr = 0; a_din = 0;
        b_req = 0; b_wr = 0; b_adr = 0; b_sadr = 0; b_din = 0;

        // reset held: INIT, we forced low
        row(0, 0,0,0,0,0, 0,0,0,0,0,   0,0,0,0,0,   1,0,16'h0,16'h0,0,0,0);
        for (int i = 0; i < 8; i++)
            row(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,i[2:0],0, 1,0,16'h0,16'h0,0,0,0);
        // A writes 3 <= A
        row(1, 1,1,3,0,4'hA, 0,0,0,0,0, 1,0,0,7,0,     0,0,16'h0,16'h0,0,0,0);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,1,3,4'hA,  1,0,16'h0,16'h0,0,0,0);
        // B reads R=3, S=5
        row(1, 0,0,0,0,0, 1,0,3,5,0,    0,1,0,3,4'hA,  0,0,16'h0,16'h0,0,0,0);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,3,4'hA,  1,0,16'h0,16'h0,0,3,5);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,3,4'hA,  0,1,16'hFFFA,16'hFFF0,1,3,5);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,3,4'hA,  0,0,16'hFFFA,16'hFFF0,1,3,5);
        // both hold req: A reads 1/2, B writes 6 <= 5; order A,B,A,B
        row(1, 1,0,1,2,0, 1,1,6,0,5,    1,0,0,3,4'hA,  0,0,16'hFFFA,16'hFFF0,1,3,5);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    0,0,0,3,4'hA,  1,0,16'hFFFA,16'hFFF0,1,1,2);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    0,1,0,3,4'hA,  0,1,16'hFFF0,16'hFFF0,0,1,2);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    0,0,1,6,5,     1,0,16'hFFF0,16'hFFF0,0,1,2);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    1,0,0,6,5,     0,0,16'hFFF0,16'hFFF0,0,1,2);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    0,0,0,6,5,     1,0,16'hFFF0,16'hFFF0,0,1,2);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    0,1,0,6,5,     0,1,16'hFFF0,16'hFFF0,0,1,2);
        row(1, 1,0,1,2,0, 1,1,6,0,5,    0,0,1,6,5,     1,0,16'hFFF0,16'hFFF0,0,1,2);
        // A reads back 6 and 3
        row(1, 1,0,6,3,0, 0,0,0,0,0,    1,0,0,6,5,     0,0,16'hFFF0,16'hFFF0,0,1,2);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,6,5,     1,0,16'hFFF0,16'hFFF0,0,6,3);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,6,5,     0,1,16'hFFF5,16'hFFFA,0,6,3);
        // A writes 2 <= F, reset lands in WR
        row(1, 1,1,2,0,4'hF, 0,0,0,0,0, 1,0,0,6,5,     0,0,16'hFFF5,16'hFFFA,0,6,3);
        row(0, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,2,4'hF,  1,0,16'hFFF5,16'hFFFA,0,6,3);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,1,0,0,     1,0,16'h0,16'h0,0,0,0);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,1,1,0,     1,0,16'h0,16'h0,0,0,0);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,1,2,0,     1,0,16'h0,16'h0,0,0,0);
        // A requests from INIT cnt=3, reset at cnt=4
        row(1, 1,0,3,6,0, 0,0,0,0,0,    0,0,1,3,0,     1,0,16'h0,16'h0,0,0,0);
        row(0, 1,0,3,6,0, 0,0,0,0,0,    0,0,0,4,0,     1,0,16'h0,16'h0,0,0,0);
        for (int i = 0; i < 8; i++)
            row(1, 1,0,3,6,0, 0,0,0,0,0, 0,0,1,i[2:0],0, 1,0,16'h0,16'h0,0,0,0);
        // first IDLE after reset: tie goes to A
        row(1, 1,0,3,6,0, 1,0,5,5,0,    1,0,0,7,0,     0,0,16'h0,16'h0,0,0,0);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,7,0,     1,0,16'h0,16'h0,0,3,6);
        row(1, 0,0,0,0,0, 0,0,0,0,0,    0,0,0,7,0,     0,1,16'hFFF0,16'hFFF0,0,3,6);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            #1 apply(vecs[i]);
            @(negedge clk);
            check($sformatf("row%0d", i), outs(), vecs[i].exp);
            @(posedge clk);
        end

        // reset during RD: no rd_valid, results cleared, INIT restarts at 0
        #1 b_req = 1; b_wr = 0; b_adr = 6; b_sadr = 3;
        @(negedge clk);
        check("rd_abort_gnt", {50'd0, b_gnt}, 51'd1);
        @(posedge clk);
        #1 b_req = 0; reset = 0;
        @(negedge clk);
        check("rd_abort_we", {49'd0, we_pulse, busy}, 51'd1);
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        check("rd_abort_out", {14'd0, rd_valid, R_out, S_out, we_pulse, W_Adr},
              {14'd0, 1'b0, 16'h0, 16'h0, 1'b1, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the reset port is synchronous and active-low.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: synchronous active-low reset, sampled on clk rising edge.
REQ-004 Ports a_req, b_req, input, 1 each: operation request from requester A or B.
REQ-005 Ports a_wr, b_wr, input, 1 each: 1 = write, 0 = read; valid while the matching req is 1.
REQ-006 Ports a_adr, b_adr, input, 3 each: write address (write) or R-port address (read).
REQ-007 Ports a_sadr, b_sadr, input, 3 each: S-port read address; ignored on writes.
REQ-008 Ports a_din, b_din, input, 4 each: write data; ignored on reads.
REQ-009 Ports a_gnt, b_gnt, output, 1 each: combinational accept strobe; the request fields are captured in the cycle gnt is 1.
REQ-010 Ports W_Adr, R_Adr, S_Adr, output, 3 each: register-file write, R-read and S-read addresses.
REQ-011 Port we_pulse, output, 1: register-file write enable, one cycle per write.
REQ-012 Port Din, output, 4: register-file write data.
REQ-013 Ports R_in, S_in, input, 16 each: register-file read data, combinational from R_Adr and S_Adr.
REQ-014 Ports R_out, S_out, output, 16 each: registered read results.
REQ-015 Port rd_valid, output, 1: one-cycle pulse marking R_out and S_out as valid.
REQ-016 Port rd_owner, output, 1: owner of the current read result, 0 = A, 1 = B; valid with rd_valid.
REQ-017 Port busy, output, 1: 1 in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: INIT, IDLE, WR and RD.
REQ-019 INIT SHALL run for 8 cycles using the 3-bit counter cnt.
- Each INIT cycle: we_pulse=1, W_Adr=cnt, Din=0.
- cnt increments every cycle.
- When cnt=7, the next state is IDLE.
REQ-020 Requests in INIT, WR and RD SHALL be ignored, with a_gnt=b_gnt=0.
REQ-021 In IDLE, when exactly one req is 1, that requester SHALL be granted in the same cycle.
REQ-022 In IDLE, when both reqs are 1, the block SHALL grant the requester not granted most recently (round-robin).
- The last-grant pointer resets to B, so A wins the first tie.
REQ-023 On a grant, the block SHALL latch the fields and move to WR if wr=1, otherwise to RD.
- Fields latched: adr, sadr, din, wr and the requester ID.
REQ-024 The WR state SHALL last one cycle.
- Outputs: we_pulse=1, W_Adr=latched adr, Din=latched din.
- Next state: IDLE.
REQ-025 The RD state SHALL last one cycle.
- Outputs: R_Adr=latched adr, S_Adr=latched sadr.
- At the RD-ending edge, R_out<=R_in, S_out<=S_in, rd_owner<=ID, and rd_valid<=1 for exactly the next cycle.
- Next state: IDLE.
REQ-026 Outside WR and INIT, we_pulse SHALL be 0, and W_Adr and Din SHALL hold their last values.
REQ-027 R_out, S_out and rd_owner SHALL hold their values until the next read completes.
REQ-028 Maximum throughput SHALL be one operation per 2 cycles (IDLE then WR or RD).
- A requester holding req high SHALL be re-granted at the next IDLE, subject to REQ-022.
REQ-029 A read of an address SHALL return the data of any write to that address granted earlier.
- This holds because WR completes before the next IDLE.

Reset
REQ-030 While reset is 0 at a clk edge, the block SHALL set:
- state=INIT, cnt=0, last-grant=B;
- W_Adr=R_Adr=S_Adr=0, Din=0;
- R_out=S_out=0, rd_valid=0, rd_owner=0.
REQ-031 we_pulse SHALL be forced to 0 whenever reset=0, including combinationally in the current cycle.
REQ-032 Reset asserted in any state, including mid-INIT, WR or RD, SHALL abort the operation with no write and no rd_valid.
- After reset is released, INIT restarts from cnt=0.
REQ-033 busy SHALL be 1 from reset until the first IDLE cycle.

Verification
REQ-034 Release reset -> 8 cycles of we_pulse=1 with W_Adr=0..7 and Din=0, busy=1; IDLE (busy=0) on cycle 9.
REQ-035 A writes adr=3, din=0xA -> a_gnt in IDLE, then one WR cycle with W_Adr=3, Din=0xA, we_pulse=1, then IDLE.
REQ-036 B reads adr=3, sadr=5; bench model returns R_in=0xFFFA, S_in=0xFFF0 -> R_out=0xFFFA, S_out=0xFFF0, rd_valid pulse, rd_owner=1.
REQ-037 A and B both hold req high for 4 grants -> grant order A, B, A, B, one grant every 2 cycles.
REQ-038 Reset asserted during WR and during INIT cnt=4 -> no we_pulse in that cycle, and INIT restarts at W_Adr=0.
REQ-039 Request during INIT cycle 3 -> no gnt until the first IDLE cycle, where it is granted.
